// File: rtl/twdl_pkg.sv
// Shared types and sizing for the FFT twiddle-index generator.
// Lane count, numerator width and legal radix range live here.
package twdl_pkg;

   localparam int N_LANES   = 5;
   localparam int W_TW      = 12;
   localparam int W_FAC     = 3;
   localparam int RADIX_MIN = 2;
   localparam int RADIX_MAX = 5;
   localparam int L_MAX     = (1 << W_TW) - 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/twdl_idx_gen_if.sv
// Control/config inputs and the twiddle beat stream of twdl_idx_gen.
// Beat handshake: a beat is transferred on a rising edge where out_val & out_rdy;
// while out_val=1 and out_rdy=0 every beat output holds stable.
interface twdl_idx_gen_if;
   import twdl_pkg::*;

   logic                             start;
   logic [W_FAC-1:0]                 cfg_factor;
   logic [W_TW-1:0]                  cfg_span;
   logic [W_TW-1:0]                  cfg_blocks;
   logic                             out_rdy;
   logic                             out_val;
   logic [W_FAC-1:0]                 factor;
   logic [0:N_LANES-1][W_TW-1:0]     twdl_numrtr;
   logic [W_TW-1:0]                  twdl_demontr;
   logic                             busy;
   logic                             done;
   logic                             cfg_err;
   state_t                           dbg_state;

   modport master (
      output start, cfg_factor, cfg_span, cfg_blocks, out_rdy,
      input  out_val, factor, twdl_numrtr, twdl_demontr, busy, done, cfg_err, dbg_state
   );

   modport slave (
      input  start, cfg_factor, cfg_span, cfg_blocks, out_rdy,
      output out_val, factor, twdl_numrtr, twdl_demontr, busy, done, cfg_err, dbg_state
   );

endinterface

// File: rtl/twdl_lane_acc.sv
// One twiddle-numerator lane: accumulates k*n by repeated addition of K.
// Lanes at or above the active radix are disabled and read as zero.
module twdl_lane_acc
   import twdl_pkg::*;
#(
   parameter int K = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            clr_i,
   input  logic            adv_i,
   output logic [W_TW-1:0] acc_o
);

   logic [W_TW-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (adv_i && en_i) begin
         acc_d = acc_q + W_TW'(K);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = en_i ? acc_q : '0;

endmodule

// File: rtl/twdl_idx_gen.sv
// Twiddle index generator for one FFT stage: emits B*M beats of per-lane
// numerators k*n over denominator L = radix*M, block index outer, n inner.
module twdl_idx_gen
   import twdl_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   twdl_idx_gen_if.slave  bus
);

   state_t                        state_q, state_d;
   logic [W_FAC-1:0]              factor_q, factor_d;
   logic [W_TW-1:0]               span_q, span_d;
   logic [W_TW-1:0]               blocks_q, blocks_d;
   logic [W_TW-1:0]               l_q, l_d;
   logic [W_TW-1:0]               n_q, n_d;
   logic [W_TW-1:0]               b_q, b_d;
   logic                          cfg_err_q, cfg_err_d;

   logic [W_FAC+W_TW-1:0]         l_full;
   logic                          legal;
   logic                          accept;
   logic                          hs;
   logic                          last_n;
   logic                          last_b;
   logic                          lane_clr;
   logic                          lane_adv;
   logic [0:N_LANES-1][W_TW-1:0]  lane_numr;

   // Full-width product so an oversize L is rejected rather than wrapped.
   assign l_full = (W_FAC+W_TW)'(bus.cfg_factor) * (W_FAC+W_TW)'(bus.cfg_span);
   assign legal  = (bus.cfg_factor >= W_FAC'(RADIX_MIN)) &&
                   (bus.cfg_factor <= W_FAC'(RADIX_MAX)) &&
                   (bus.cfg_span != '0) && (bus.cfg_blocks != '0) &&
                   (l_full <= (W_FAC+W_TW)'(L_MAX));

   assign accept = (state_q == IDLE) && bus.start && legal;
   assign hs     = (state_q == RUN) && bus.out_rdy;
   assign last_n = (n_q == span_q - 1'b1);
   assign last_b = (b_q == blocks_q - 1'b1);

   always_comb begin
      state_d   = state_q;
      factor_d  = factor_q;
      span_d    = span_q;
      blocks_d  = blocks_q;
      l_d       = l_q;
      n_d       = n_q;
      b_d       = b_q;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (legal) begin
                  state_d  = RUN;
                  factor_d = bus.cfg_factor;
                  span_d   = bus.cfg_span;
                  blocks_d = bus.cfg_blocks;
                  l_d      = l_full[W_TW-1:0];
                  n_d      = '0;
                  b_d      = '0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (hs) begin
               if (last_n) begin
                  n_d = '0;
                  if (last_b) begin
                     b_d     = '0;
                     state_d = IDLE;
                  end else begin
                     b_d = b_q + 1'b1;
                  end
               end else begin
                  n_d = n_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         factor_q  <= '0;
         span_q    <= '0;
         blocks_q  <= '0;
         l_q       <= '0;
         n_q       <= '0;
         b_q       <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         factor_q  <= factor_d;
         span_q    <= span_d;
         blocks_q  <= blocks_d;
         l_q       <= l_d;
         n_q       <= n_d;
         b_q       <= b_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // Accumulators restart at every accepted start and at every n wrap.
   assign lane_clr = accept | (hs & last_n);
   assign lane_adv = hs & ~last_n;

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      twdl_lane_acc #(.K(k)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en_i  (factor_q > W_FAC'(k)),
         .clr_i (lane_clr),
         .adv_i (lane_adv),
         .acc_o (lane_numr[k])
      );
   end

   assign bus.out_val      = (state_q == RUN);
   assign bus.busy         = (state_q == RUN);
   assign bus.done         = hs & last_n & last_b;
   assign bus.cfg_err      = cfg_err_q;
   assign bus.factor       = factor_q;
   assign bus.twdl_demontr = l_q;
   assign bus.twdl_numrtr  = lane_numr;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_twdl_idx_gen.sv
// Scoreboard bench for twdl_idx_gen: a reference model queues expected beats
// per accepted start; a negedge monitor compares every presented beat.
module tb_twdl_idx_gen;
   import twdl_pkg::*;

   logic clk;
   logic rst_n;

   twdl_idx_gen_if bus ();

   twdl_idx_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int done_seen = 0;
   int rdy_mode  = 0;
   int rdy_phase = 0;

   // Entry: {last beat, factor, L, lane0..lane4 numerators}
   logic [75:0] exp_q[$];
   logic [75:0] mon_exp;
   logic [75:0] mon_act;

   // ---------------- downstream ready driver ----------------
   initial begin
      bus.out_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.out_rdy = 1'b1;
            1:       bus.out_rdy = (rdy_phase % 3 == 0);
            default: bus.out_rdy = 1'($urandom_range(0, 1));
         endcase
         rdy_phase++;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_val) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected: got beat %h, required no beat",
                        {bus.done, bus.factor, bus.twdl_demontr, bus.twdl_numrtr});
            end else begin
               mon_exp = {exp_q[0][75] & bus.out_rdy, exp_q[0][74:0]};
               mon_act = {bus.done, bus.factor, bus.twdl_demontr, bus.twdl_numrtr};
               if (mon_act !== mon_exp) begin
                  errors++;
                  $display("FAIL beat: got %h required %h (rdy=%0b)", mon_act, mon_exp, bus.out_rdy);
               end
               if (bus.out_rdy) void'(exp_q.pop_front());
            end
         end else begin
            checks++;
            if (bus.done !== 1'b0) begin
               errors++;
               $display("FAIL done_idle: got %b required 0", bus.done);
            end
         end
         if (bus.done === 1'b1) done_seen++;
      end
   end

   // ---------------- reference model ----------------
   function automatic bit model_legal(input int f, input int m, input int b);
      return (f >= 2) && (f <= 5) && (m >= 1) && (b >= 1) && (f * m <= 4095);
   endfunction

   task automatic push_model(input int f, input int m, input int b);
      logic [0:4][11:0] nv;
      logic             last;
      for (int bb = 0; bb < b; bb++) begin
         for (int n = 0; n < m; n++) begin
            for (int k = 0; k < 5; k++) nv[k] = (k < f) ? 12'(k * n) : 12'd0;
            last = (bb == b - 1) && (n == m - 1);
            exp_q.push_back({last, 3'(f), 12'(f * m), nv});
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Call at posedge+1; start is sampled on the next rising edge.
   task automatic pulse_now(input int f, input int m, input int b, input bit expect_accept);
      bus.start      = 1'b1;
      bus.cfg_factor = 3'(f);
      bus.cfg_span   = 12'(m);
      bus.cfg_blocks = 12'(b);
      if (expect_accept) push_model(f, m, b);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      int cnt = 0;
      while ((exp_q.size() != 0 || bus.busy) && cnt < 20000) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      checks++;
      if (cnt >= 20000) begin
         errors++;
         $display("FAIL idle_timeout: got %0d pending beats, required 0", exp_q.size());
         exp_q.delete();
      end
      check("out_val_after_run", 64'(bus.out_val), 64'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_out_val"}, 64'(bus.out_val), 64'd0);
      check({tag, "_busy"},    64'(bus.busy), 64'd0);
      check({tag, "_done"},    64'(bus.done), 64'd0);
      check({tag, "_cfg_err"}, 64'(bus.cfg_err), 64'd0);
      check({tag, "_factor"},  64'(bus.factor), 64'd0);
      check({tag, "_demontr"}, 64'(bus.twdl_demontr), 64'd0);
      check({tag, "_numrtr"},  64'(bus.twdl_numrtr), 64'd0);
      check({tag, "_state"},   64'(bus.dbg_state), 64'(IDLE));
   endtask

   task automatic issue(input int f, input int m, input int b);
      bit legal;
      int d0;
      legal = model_legal(f, m, b);
      d0    = done_seen;
      rdy_phase = 0;
      pulse_now(f, m, b, legal);
      check("cfg_err", 64'(bus.cfg_err), 64'(!legal));
      check("busy",    64'(bus.busy), 64'(legal));
      if (!legal) begin
         @(posedge clk);
         #1;
         check("cfg_err_pulse", 64'(bus.cfg_err), 64'd0);
         check("busy_rejected", 64'(bus.busy), 64'd0);
      end
      wait_idle();
      check("done_count", 64'(done_seen - d0), legal ? 64'd1 : 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0;
      bus.start      = 1'b0;
      bus.cfg_factor = '0;
      bus.cfg_span   = '0;
      bus.cfg_blocks = '0;
      rst_n          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_zero("reset");

      rdy_mode = 0;
      issue(3, 4, 2);

      rdy_mode = 1;
      issue(5, 3, 1);

      rdy_mode = 0;
      issue(6, 4, 1);
      issue(5, 1000, 1);
      issue(3, 0, 2);
      issue(2, 4, 0);
      issue(1, 4, 1);
      issue(3, 1365, 1);
      issue(3, 1366, 1);

      // start arriving mid-run is ignored
      d0 = done_seen;
      pulse_now(2, 8, 4, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      pulse_now(3, 5, 5, 1'b0);
      check("cfg_err_in_run", 64'(bus.cfg_err), 64'd0);
      wait_idle();
      check("done_count_ignored_start", 64'(done_seen - d0), 64'd1);

      // reset mid-run aborts without done, then an immediate start is accepted
      d0 = done_seen;
      pulse_now(3, 10, 5, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      check_zero("midrun_reset");
      check("done_count_abort", 64'(done_seen - d0), 64'd0);
      issue(4, 2, 1);

      // M=1 run with restart on the cycle after done
      d0 = done_seen;
      pulse_now(2, 1, 3, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      pulse_now(2, 1, 3, 1'b1);
      check("busy_back_to_back", 64'(bus.busy), 64'd1);
      wait_idle();
      check("done_count_b2b", 64'(done_seen - d0), 64'd2);

      // start coinciding with the final handshake is ignored
      d0 = done_seen;
      pulse_now(3, 1, 1, 1'b1);
      pulse_now(4, 2, 2, 1'b0);
      check("busy_after_coincide", 64'(bus.busy), 64'd0);
      wait_idle();
      check("done_count_coincide", 64'(done_seen - d0), 64'd1);

      // randomized configurations and ready patterns
      for (int i = 0; i < 30; i++) begin
         int f, m, b;
         rdy_mode = $urandom_range(0, 2);
         f = $urandom_range(1, 6);
         m = $urandom_range(0, 12);
         b = $urandom_range(0, 4);
         issue(f, m, b);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/twdl_idx_gen.md
TWDL_IDX_GEN -- requirements
Module: twdl_idx_gen

Interface
REQ-001 SHALL expose: clk  input  1  clock; all logic on rising edge.
REQ-002 SHALL expose: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL expose: start  input  1  one-cycle request to run one FFT stage's twiddle sequence.
REQ-004 SHALL expose: cfg_factor  input  3  stage radix; legal values 2..5.
REQ-005 SHALL expose: cfg_span  input  12  butterflies per block, M; legal 1..4095.
REQ-006 SHALL expose: cfg_blocks  input  12  blocks per stage, B; legal 1..4095.
REQ-007 SHALL expose: out_rdy  input  1  downstream twiddle stage accepts the current beat.
REQ-008 SHALL expose: out_val  output  1  current beat valid.
REQ-009 SHALL expose: factor  output  3  latched radix.
REQ-010 SHALL expose: twdl_numrtr  output  5x12  per-lane twiddle numerator; lane 0 is MSB-first index 0.
REQ-011 SHALL expose: twdl_demontr  output  12  twiddle denominator, L = factor*M.
REQ-012 SHALL expose: busy  output  1  high in RUN.
REQ-013 SHALL expose: done  output  1  one-cycle pulse when the final beat is accepted.
REQ-014 SHALL expose: cfg_err  output  1  one-cycle pulse when start is rejected for an illegal configuration.

Function
REQ-015 FSM SHALL have states IDLE and RUN only.
REQ-016 In IDLE, start SHALL latch cfg_factor, cfg_span and cfg_blocks, compute L = cfg_factor*cfg_span at full width, and enter RUN on the next cycle.
REQ-017 Start SHALL be rejected with cfg_err=1 on the next cycle, staying in IDLE, if cfg_factor is not in 2..5, cfg_span=0, cfg_blocks=0, or L>4095.
REQ-018 Start SHALL be ignored while in RUN, with no cfg_err and no change to latched config.
REQ-019 In RUN, out_val SHALL be 1 continuously, starting the cycle after start is accepted (latency 1).
REQ-020 Exactly B*M beats SHALL be emitted; order: block index b outer (0..B-1), butterfly index n inner (0..M-1).
REQ-021 For lane k < factor, twdl_numrtr[k] SHALL equal k*n; lanes k >= factor SHALL output 0; lane 0 is always 0.
REQ-022 Numerators SHALL be produced by per-lane accumulators (add k per advance, clear to 0 when n wraps from M-1 to 0), with no multipliers; k*n < L is guaranteed, so no modulo is needed.
REQ-023 twdl_demontr SHALL hold L and factor SHALL hold the latched radix for the whole of RUN.
REQ-024 A beat SHALL advance only when out_val & out_rdy; while out_rdy=0, all outputs SHALL hold stable.
REQ-025 On the handshake of beat n=M-1, b=B-1, the FSM SHALL return to IDLE and assert done that same cycle; out_val SHALL be 0 on the next cycle.
REQ-026 Where the final handshake and a new start coincide, the start SHALL be ignored, since the FSM is still in RUN at that edge.
REQ-027 M=1 SHALL yield all-zero numerators for B beats.
REQ-028 A back-to-back start in the cycle after done SHALL be accepted.

Reset
REQ-029 rst_n=0 SHALL force IDLE; out_val, busy, done, cfg_err = 0; factor, twdl_numrtr, twdl_demontr = 0; all counters = 0.
REQ-030 Reset asserted mid-RUN SHALL abort the sequence with no done pulse; the first cycle after reset SHALL be IDLE and SHALL accept start.

Structure
REQ-031 Package twdl_pkg SHALL hold: the state enum (IDLE, RUN), N_LANES=5, W_TW=12, RADIX_MIN=2, RADIX_MAX=5.
REQ-032 Sub-module twdl_lane_acc (one per lane, parameter lane index k) SHALL hold the numerator accumulator with clear/advance/enable controls; the n and b counters stay in the top level.

Verification
REQ-033 factor=3, M=4, B=2, out_rdy=1 -> 8 beats; lane1 0,1,2,3,0,1,2,3; lane2 0,2,4,6 repeated; lanes3-4 0; demontr=12; done on beat 8.
REQ-034 factor=5, M=3, B=1, out_rdy toggling 1,0,0,1,... -> values held during stalls; lane4 sequence 0,4,8; exactly 3 accepted beats; done once.
REQ-035 Illegal configurations: start with factor=6 -> cfg_err pulse, busy stays 0; factor=5, M=1000 (L=5000) -> cfg_err; M=0 -> cfg_err.
REQ-036 start asserted at cycle 3 of a RUN with factor=2, M=8, B=4 -> ignored; sequence completes with 32 beats and demontr=16.
REQ-037 rst_n low for 1 cycle mid-RUN -> all outputs 0, no done; a following start with factor=4, M=2, B=1 yields lane3 sequence 0,3.
REQ-038 factor=2, M=1, B=3 -> 3 beats, all numerators 0, demontr=2; a restart on the cycle after done is accepted.
